// File: rtl/fetch_mem_responder.sv
// Halfword RAM window responder for the CPU fetch bus (req/ack/err handshake).
// Latency: ack WAIT_STATES+2 edges after req is sampled in IDLE; err after 1 edge.
// Backpressure: none; initiator holds req and operands stable, one IDLE cycle between transactions.
module fetch_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hFF000000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addrbus,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Counter starts at WAIT_STATES-1 so the FSM spends exactly WAIT_STATES cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             wait_cnt;
  logic [3:0]             wait_cnt_nxt;
  logic                   capture;
  logic                   in_window;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   we_q;
  logic [15:0]            wdat_q;
  logic [15:0]            mem [DEPTH];

  assign in_window = (addrbus[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);

  // Next-state, wait-counter and capture-strobe decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (!in_window) begin
            state_nxt = ST_ERR;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = ST_ACCESS;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state, so each pulse lasts one cycle.
  always_comb begin
    ack  = (state == ST_RESP);
    err  = (state == ST_ERR);
    busy = (state != ST_IDLE);
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Request operands are latched once in IDLE; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      idx_q  <= addrbus[ADDR_BITS-1:0];
      we_q   <= we;
      wdat_q <= data_in;
    end
  end

  // Single-port RAM access at the ACCESS edge; reset wins over a coinciding write.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 16'h0000;
    end else if (state == ST_ACCESS) begin
      if (we_q) begin
        mem[idx_q] <= wdat_q;
      end else begin
        data_out <= mem[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Self-checking bench: WAIT_STATES=1 instance (a) and WAIT_STATES=0 instance (b).
// Table vectors, hand-written multi-cycle sequences, and random traffic against a memory model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_fetch_mem_responder;

  localparam logic [31:0] BASE = 32'hFF000000;

  logic        clk;
  logic        rst;
  logic [31:0] addr_a, addr_b;
  logic        req_a, req_b, we_a, we_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;
  int both_cnt = 0;

  fetch_mem_responder #(.BASE_ADDR(BASE), .ADDR_BITS(10), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .rst(rst), .addrbus(addr_a), .req(req_a), .we(we_a), .data_in(din_a),
    .data_out(dout_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  fetch_mem_responder #(.BASE_ADDR(BASE), .ADDR_BITS(10), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst(rst), .addrbus(addr_b), .req(req_b), .we(we_b), .data_in(din_b),
    .data_out(dout_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ack and err must never be high together on either instance.
  always @(negedge clk) begin
    if (ack_a && err_a) both_cnt++;
    if (ack_b && err_b) both_cnt++;
  end

  // Reference model for instance a: RAM contents written so far and expected data_out.
  logic [15:0] mem_m [int];
  logic [15:0] dout_m = 16'h0000;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [15:0] d;
    logic        e;
    int          lat;
    logic [15:0] dout;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one request and wait (bounded) for ack or err.
  task automatic txn(input bit inst, input logic w, input logic [31:0] a, input logic [15:0] d,
                     input bit hold, output int edges, output logic ga, output logic ge,
                     output logic [15:0] dv);
    if (!inst) begin req_a = 1'b1; we_a = w; addr_a = a; din_a = d; end
    else       begin req_b = 1'b1; we_b = w; addr_b = a; din_b = d; end
    edges = 0; ga = 1'b0; ge = 1'b0;
    while (edges < 20 && !ga && !ge) begin
      @(posedge clk); #1;
      edges++;
      ga = inst ? ack_b : ack_a;
      ge = inst ? err_b : err_a;
    end
    dv = inst ? dout_b : dout_a;
    if (!hold) begin
      if (!inst) req_a = 1'b0; else req_b = 1'b0;
    end
  endtask

  // Full transaction on instance a with checks, then model update.
  task automatic apply(input string nm, input logic w, input logic [31:0] a, input logic [15:0] d,
                       input logic exp_err, input int exp_lat, input logic [15:0] exp_dout);
    int edges;
    logic ga, ge;
    logic [15:0] dv;
    txn(1'b0, w, a, d, 1'b0, edges, ga, ge, dv);
    chk({nm, "_lat"}, edges, exp_lat);
    chk({nm, "_ack"}, ga, !exp_err);
    chk({nm, "_err"}, ge, exp_err);
    chk({nm, "_dout"}, dv, exp_dout);
    @(posedge clk); #1;
    chk({nm, "_after"}, {ack_a, err_a, busy_a}, 3'b000);
    chk({nm, "_hold"}, dout_a, exp_dout);
    if (a[31:10] == BASE[31:10]) begin
      if (w) mem_m[int'(a[9:0])] = d;
      else   dout_m = mem_m[int'(a[9:0])];
    end
  endtask

  int          edges, n_ack;
  logic        ga, ge;
  logic [15:0] dv;
  int          at [3];
  logic [31:0] r_a;
  logic [15:0] r_d, r_exp;
  logic        r_w, r_oow;
  int          r_idx;

  initial begin
    tbl[0]  = '{1'b1, 32'hFF000004, 16'hBEEF, 1'b0, 3, 16'h0000};
    tbl[1]  = '{1'b0, 32'hFF000004, 16'h0000, 1'b0, 3, 16'hBEEF};
    tbl[2]  = '{1'b1, 32'hFF000000, 16'h8123, 1'b0, 3, 16'hBEEF};
    tbl[3]  = '{1'b1, 32'hFF000001, 16'h4567, 1'b0, 3, 16'hBEEF};
    tbl[4]  = '{1'b1, 32'hFF000010, 16'hAAAA, 1'b0, 3, 16'hBEEF};
    tbl[5]  = '{1'b1, 32'hFF0003FF, 16'h0F0F, 1'b0, 3, 16'hBEEF};
    tbl[6]  = '{1'b0, 32'hFF0003FF, 16'h0000, 1'b0, 3, 16'h0F0F};
    tbl[7]  = '{1'b0, 32'hFF000400, 16'h0000, 1'b1, 1, 16'h0F0F};
    tbl[8]  = '{1'b0, 32'hFEFFFFFF, 16'h0000, 1'b1, 1, 16'h0F0F};
    tbl[9]  = '{1'b1, 32'h00001000, 16'h9999, 1'b1, 1, 16'h0F0F};
    tbl[10] = '{1'b0, 32'hFF000000, 16'h0000, 1'b0, 3, 16'h8123};

    // Reset held two cycles with req high on both instances.
    rst = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = BASE; din_a = 16'h0;
    req_b = 1'b1; we_b = 1'b0; addr_b = BASE; din_b = 16'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_a", {ack_a, err_a, busy_a, dout_a}, 19'h0);
      chk("rst_b", {ack_b, err_b, busy_b, dout_b}, 19'h0);
    end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_a", {ack_a, err_a, busy_a, dout_a}, 19'h0);
    chk("rst_rel_b", {ack_b, err_b, busy_b, dout_b}, 19'h0);

    // Table vectors on the WAIT_STATES=1 instance.
    for (int i = 0; i < 11; i++)
      apply($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].lat, tbl[i].dout);

    // Two-halfword fetch, req held across both transactions.
    txn(1'b0, 1'b0, 32'hFF000000, 16'h0, 1'b1, edges, ga, ge, dv);
    chk("b2b1_lat", edges, 3);
    chk("b2b1_dout", dv, 16'h8123);
    addr_a = 32'hFF000001;
    @(posedge clk); #1;
    chk("b2b_idle", {ack_a, busy_a}, 2'b00);
    txn(1'b0, 1'b0, 32'hFF000001, 16'h0, 1'b0, edges, ga, ge, dv);
    chk("b2b2_lat", edges, 3);
    chk("b2b2_dout", dv, 16'h4567);
    @(posedge clk); #1;
    dout_m = mem_m[1];

    // Out-of-window read leaves data_out alone; a later in-window read is fine.
    apply("oow", 1'b0, 32'h00001000, 16'h0, 1'b1, 1, 16'h4567);
    apply("post_oow", 1'b0, 32'hFF000000, 16'h0, 1'b0, 3, 16'h8123);

    // Reset while a write sits in WAIT: write discarded, no ack.
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'hFF000010; din_a = 16'h1234;
    @(posedge clk); #1;
    chk("rstw_busy", busy_a, 1'b1);
    rst = 1'b1; req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_idle", {busy_a, dout_a}, 17'h0);
    n_ack = 0;
    repeat (4) begin @(posedge clk); #1; if (ack_a) n_ack++; end
    chk("rstw_noack", n_ack, 0);

    // Reset on the same edge as the ACCESS edge of a write: reset wins.
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'hFF000010; din_a = 16'h5555;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rsta_idle", busy_a, 1'b0);
    n_ack = 0;
    repeat (3) begin @(posedge clk); #1; if (ack_a) n_ack++; end
    chk("rsta_noack", n_ack, 0);
    dout_m = 16'h0000;
    apply("rst_readback", 1'b0, 32'hFF000010, 16'h0, 1'b0, 3, 16'hAAAA);

    // Random traffic checked against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r_a = $urandom;
        if (r_a[31:10] == BASE[31:10]) r_a[31] = ~r_a[31];
        r_oow = 1'b1; r_idx = 0;
      end else begin
        r_idx = $urandom_range(256, 271);
        r_a = BASE | 32'(r_idx);
        r_oow = 1'b0;
      end
      r_w = 1'($urandom_range(0, 1));
      if (!r_oow && !mem_m.exists(r_idx)) r_w = 1'b1;
      r_d = 16'($urandom);
      r_exp = (!r_oow && !r_w) ? mem_m[r_idx] : dout_m;
      apply("rand", r_w, r_a, r_d, r_oow, r_oow ? 1 : 3, r_exp);
    end

    // WAIT_STATES=0 instance: two-edge latency.
    txn(1'b1, 1'b1, 32'hFF000020, 16'h1357, 1'b0, edges, ga, ge, dv);
    chk("ws0_w_lat", edges, 2);
    chk("ws0_w_dout", dv, 16'h0000);
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'hFF000020, 16'h0, 1'b0, edges, ga, ge, dv);
    chk("ws0_r_lat", edges, 2);
    chk("ws0_r_dout", dv, 16'h1357);
    @(posedge clk); #1;

    // Continuous req: three acks, three cycles apart.
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'hFF000020;
    n_ack = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (ack_b) begin
        if (n_ack < 3) at[n_ack] = c;
        n_ack++;
      end
      if (c == 8) req_b = 1'b0;
    end
    chk("ws0_cont_n", n_ack, 3);
    chk("ws0_cont_t0", at[0], 2);
    chk("ws0_cont_gap1", at[1] - at[0], 3);
    chk("ws0_cont_gap2", at[2] - at[1], 3);
    chk("ws0_cont_dout", dout_b, 16'h1357);

    repeat (2) @(posedge clk);
    #1;
    chk("ack_err_excl", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_mem_responder.md
Name: fetch_mem_responder

Overview:
- Memory-side responder for the CPU's 32-bit-address / 16-bit-data fetch bus: serves halfword reads and writes from an internal RAM window.
- Sits between the CPU fetch/decode logic and on-chip monitor memory at BASE_ADDR.
- Addresses are halfword addresses; the CPU PC increments by 1 per halfword.
- Uses a req/ack/err handshake with programmable wait states and out-of-window error reporting.

Parameters:
- BASE_ADDR, 32'hFF000000, halfword base address of the window; must be aligned to 2^ADDR_BITS.
- ADDR_BITS, 10, log2 of RAM depth in halfwords (default 1024 x 16).
- WAIT_STATES, 1, extra stall cycles per access; range 0..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addrbus  in  32  halfword address from the initiator.
- req  in  1  request; held high with addrbus/we/data_in stable until ack or err.
- we  in  1  1 = write, 0 = read.
- data_in  in  16  write data from the initiator.
- data_out  out  16  read data to the initiator.
- ack  out  1  one-cycle pulse: access completed.
- err  out  1  one-cycle pulse: address outside the window.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: state=IDLE, ack=0, err=0, busy=0, data_out=16'h0000, wait counter=0.
  - RAM contents are not cleared.
- In-window test: addrbus[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]. RAM index = addrbus[ADDR_BITS-1:0].
- FSM states: IDLE, WAIT, ACCESS, RESP, ERR.
  - IDLE: on req=1, capture addr, we and data_in into registers; these are the only values used afterwards.
    - Out-of-window request -> ERR.
    - Else WAIT_STATES>0 -> WAIT, with counter loaded to WAIT_STATES-1.
    - Else -> ACCESS.
  - WAIT: decrement the counter; when counter==0, go to ACCESS.
  - ACCESS: a write updates RAM at this edge; a read latches RAM[index] into data_out at this edge. Then go to RESP.
  - RESP: ack=1 for exactly this cycle, then go to IDLE.
  - ERR: err=1 for exactly this cycle, with no RAM access and data_out unchanged, then go to IDLE.
- Latency, counted in rising edges from the edge that samples req in IDLE to the first cycle with ack high: WAIT_STATES+2. err appears after 1 edge.
- data_out changes only at the ACCESS edge of a read. It holds its value through ack and afterwards. Writes leave it unchanged.
- ack and err are never high together. Neither is ever high outside RESP/ERR.
- Back-to-back: if req is still high in the IDLE cycle following ack/err, it is a new request. The initiator must present its next address by then, so one idle cycle separates transactions.
  - A two-halfword fetch (first word bit15=1) therefore completes as two full transactions.
- req deasserted mid-transaction: the transaction completes normally on the captured values; ack/err still pulse.
- Reset mid-operation: state returns to IDLE.
  - A write not yet at the ACCESS edge is discarded.
  - A write whose ACCESS edge coincides with the rst=1 edge is also discarded; reset has priority.
- Wait counter width is 4 bits. WAIT_STATES=0 bypasses the WAIT state entirely.
- RAM is inferable single-port synchronous memory; no read-during-write case arises.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=1 -> ack=0, err=0, busy=0, data_out=0000 throughout and one cycle after release.
- WAIT_STATES=1, write: addr FF000004, data BEEF -> ack on the 3rd edge. Read of FF000004 -> ack on the 3rd edge with data_out=BEEF; data_out stays BEEF after ack.
- Two-halfword fetch: preload FF000000=8123 and FF000001=4567; read FF000000 then FF000001 back-to-back -> acks with data 8123 then 4567; exactly one idle cycle between ack and the next busy.
- Out of window: read 00001000 -> err pulses one cycle after 1 edge; ack never asserts; data_out keeps its prior value. A later read of FF000000 is unaffected.
- Reset mid-write: write 1234 to FF000010 over old value AAAA; assert rst during WAIT -> no ack. Readback after reset gives AAAA.
- WAIT_STATES=0 instance: read -> ack on the 2nd edge. A req held continuously across 3 transactions yields 3 ack pulses spaced 3 cycles apart.
